// File: rtl/sap_pkg.sv
// Shared types and constants for the SAP-class datapath blocks.
// The divider FSM states live here so the ALU side and the co-unit agree on them.
package sap_pkg;

    localparam int SAP_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/sub_bh.sv
// Combinational N-bit subtractor with borrow-in, shaped like the SAP adder.
// Computes a - b - bin; borrow is set when the true result is negative.
module sub_bh #(
    parameter int N = 5
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic [N-1:0] diff,
    output logic         borrow
);

    logic [N:0] full;

    // The extra top bit of the widened difference is the borrow-out.
    assign full   = {1'b0, a} - {1'b0, b} - {{N{1'b0}}, bin};
    assign diff   = full[N-1:0];
    assign borrow = full[N];

endmodule

// File: rtl/seq_div_bh.sv
// Multicycle unsigned restoring divider: one quotient bit per clock.
// A zero divisor short-circuits straight to DONE with all-ones quotient.
module seq_div_bh
    import sap_pkg::*;
#(
    parameter int WIDTH = SAP_WIDTH
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    div_state_t       state, state_nxt;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] q_sh;
    logic [WIDTH:0]   pr;
    logic [CNT_W-1:0] cnt;

    logic             accept;
    logic             last_step;
    logic [WIDTH:0]   pr_shift;
    logic [WIDTH:0]   trial;
    logic             borrow;
    logic [WIDTH:0]   pr_step;
    logic [WIDTH-1:0] q_step;
    logic             unused_pr_msb;

    assign accept    = start && (state == IDLE || state == DONE);
    assign last_step = (state == RUN) && (cnt == '0);
    assign busy      = (state == RUN);
    assign done      = (state == DONE);

    // Bring the next dividend bit into the partial remainder, then try the subtract.
    assign pr_shift = {pr[WIDTH-1:0], q_sh[WIDTH-1]};

    sub_bh #(.N(WIDTH + 1)) u_sub (
        .a      (pr_shift),
        .b      ({1'b0, dvs}),
        .bin    (1'b0),
        .diff   (trial),
        .borrow (borrow)
    );

    assign pr_step = borrow ? pr_shift : trial;
    assign q_step  = {q_sh[WIDTH-2:0], ~borrow};

    // The restored remainder is always below the divisor, so the top PR bit stays zero.
    assign unused_pr_msb = pr[WIDTH];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: defaults first so every path assigns state_nxt and no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE: begin
                if (accept)              state_nxt = (divisor == '0) ? DONE : RUN;
                else if (state == DONE)  state_nxt = IDLE;
            end
            RUN: begin
                if (cnt == '0) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            dvs       <= '0;
            q_sh      <= '0;
            pr        <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else if (accept) begin
            dvs  <= divisor;
            q_sh <= dividend;
            pr   <= '0;
            cnt  <= CNT_W'(WIDTH - 1);
            if (divisor == '0) begin
                quotient  <= '1;
                remainder <= dividend;
                div_zero  <= 1'b1;
            end
        end else if (state == RUN) begin
            pr   <= pr_step;
            q_sh <= q_step;
            cnt  <= cnt - CNT_W'(1);
            if (last_step) begin
                quotient  <= q_step;
                remainder <= pr_step[WIDTH-1:0];
                div_zero  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_div_bh.sv
// Self-checking bench for seq_div_bh: directed cases plus a shuffled sweep of
// every operand pair against a plain-arithmetic reference.
module tb_seq_div_bh;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         clr_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_zero;

    int total = 0;
    int bad   = 0;

    // Last result the bench expects the DUT to be holding.
    int last_q  = 0;
    int last_r  = 0;
    int last_dz = 0;

    seq_div_bh #(.WIDTH(W)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic ref_div(input int a, input int b, output int q, output int r, output int dz);
        if (b == 0) begin
            q  = (1 << W) - 1;
            r  = a;
            dz = 1;
        end else begin
            q  = a / b;
            r  = a % b;
            dz = 0;
        end
    endtask

    task automatic check_result(input string tag, input int a, input int b);
        int q, r, dz;
        ref_div(a, b, q, r, dz);
        check({tag, " quotient"}, quotient, q);
        check({tag, " remainder"}, remainder, r);
        check({tag, " div_zero"}, div_zero, dz);
        last_q  = q;
        last_r  = r;
        last_dz = dz;
    endtask

    // One full transaction from IDLE; verifies latency, busy profile, held outputs and the DONE pulse.
    task automatic do_op(input int a, input int b, input string tag);
        int lat;
        int exp_lat;
        exp_lat = (b == 0) ? 0 : W;
        @(negedge clk);
        dividend = a[W-1:0];
        divisor  = b[W-1:0];
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        for (int k = 0; k <= W + 2; k++) begin
            @(negedge clk);
            if (done) break;
            check({tag, " busy"}, busy, 1'b1);
            check({tag, " held q"}, quotient, last_q);
            lat++;
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " busy at done"}, busy, 1'b0);
        check_result(tag, a, b);
        @(negedge clk);
        check({tag, " done pulse"}, done, 1'b0);
    endtask

    int perm [256];
    int done_cyc [$];

    initial begin
        // Reset state
        #1;
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset quotient", quotient, 0);
        check("reset remainder", remainder, 0);
        check("reset div_zero", div_zero, 1'b0);
        @(negedge clk);
        clr_n = 1'b1;

        // Basic divisions
        do_op(13, 3, "13/3");
        do_op(15, 1, "15/1");
        do_op(3, 7, "3/7");
        do_op(0, 5, "0/5");

        // Divide by zero, then a normal op clears the flag
        do_op(9, 0, "9/0");
        do_op(8, 2, "8/2");

        // START while busy is ignored
        begin
            int lat;
            @(negedge clk);
            dividend = 4'd14;
            divisor  = 4'd4;
            start    = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            @(negedge clk);
            check("ign busy", busy, 1'b1);
            dividend = 4'd7;
            divisor  = 4'd7;
            start    = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            lat = 1;
            for (int k = 0; k <= W + 2; k++) begin
                @(negedge clk);
                if (done) break;
                lat++;
            end
            check("ign latency", lat, W);
            check_result("ign 14/4", 14, 4);
            for (int k = 0; k < 2 * W; k++) begin
                @(negedge clk);
                check("ign no 2nd done", done, 1'b0);
            end
        end

        // Asynchronous reset mid-operation
        begin
            @(negedge clk);
            dividend = 4'd12;
            divisor  = 4'd5;
            start    = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            @(posedge clk);
            @(posedge clk);
            #3 clr_n = 1'b0;
            #1;
            check("rst busy", busy, 1'b0);
            check("rst done", done, 1'b0);
            check("rst quotient", quotient, 0);
            check("rst remainder", remainder, 0);
            check("rst div_zero", div_zero, 1'b0);
            @(negedge clk);
            clr_n = 1'b1;
            last_q  = 0;
            last_r  = 0;
            last_dz = 0;
            for (int k = 0; k < 2 * W; k++) begin
                @(negedge clk);
                check("rst no done", done, 1'b0);
            end
            do_op(12, 5, "12/5 after rst");
        end

        // START held high: one result every W+1 cycles
        begin
            @(negedge clk);
            dividend = 4'd10;
            divisor  = 4'd3;
            start    = 1'b1;
            for (int c = 0; c < 4 * (W + 1) + 1; c++) begin
                @(negedge clk);
                if (done) begin
                    done_cyc.push_back(c);
                    check_result("held 10/3", 10, 3);
                end
            end
            start = 1'b0;
            check("held done count", done_cyc.size(), 4);
            for (int i = 0; i < done_cyc.size(); i++)
                check("held done cycle", done_cyc[i], W + i * (W + 1));
            for (int k = 0; k <= W + 2; k++) begin
                @(negedge clk);
                if (done) break;
            end
            check("held drain done", done, 1'b1);
            @(negedge clk);
        end

        // Shuffled sweep of every operand pair
        for (int i = 0; i < 256; i++) perm[i] = i;
        for (int i = 255; i > 0; i--) begin
            int j;
            int tmp;
            j = $urandom_range(i, 0);
            tmp = perm[i];
            perm[i] = perm[j];
            perm[j] = tmp;
        end
        for (int i = 0; i < 256; i++) begin
            int a;
            int b;
            int gap;
            a = perm[i] >> W;
            b = perm[i] % (1 << W);
            gap = $urandom_range(2, 0);
            for (int g = 0; g < gap; g++) @(negedge clk);
            do_op(a, b, "sweep");
            if (b != 0) begin
                check("sweep inv q*d+r", quotient * b + remainder, a);
                check("sweep inv r<d", remainder < b, 1'b1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
